// File: rtl/fb_skip_controller_if.sv
// rtl/fb_skip_controller_if.sv - configuration handshake bundle for the feedback skip controller
// Master offers a frame length/skip pair; slave reports when it can take another.
interface fb_skip_controller_if #(
    parameter int WIDTH = 6
);
    logic             cfgValid;
    logic [WIDTH-1:0] cfgLen;
    logic [WIDTH-1:0] cfgSkip;
    logic             cfgReady;

    modport master (
        output cfgValid,
        output cfgLen,
        output cfgSkip,
        input  cfgReady
    );

    modport slave (
        input  cfgValid,
        input  cfgLen,
        input  cfgSkip,
        output cfgReady
    );
endinterface

// File: rtl/fb_skip_controller.sv
// rtl/fb_skip_controller.sv - frame phase counter driving prescaler skips and a divided feedback clock
// Configuration changes are staged and only take effect on a frame boundary while running.
module fb_skip_controller #(
    parameter int WIDTH        = 6,
    parameter int DEFAULT_LEN  = 32,
    parameter int DEFAULT_SKIP = 0
) (
    input  logic                clk1G28,
    input  logic                rst,
    input  logic                enable,
    fb_skip_controller_if.slave cfg,
    output logic                skip,
    output logic                frameStart,
    output logic                divClk
);
    localparam logic [WIDTH-1:0] DEF_LEN  = WIDTH'(DEFAULT_LEN);
    localparam logic [WIDTH-1:0] DEF_SKIP = WIDTH'(DEFAULT_SKIP);
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] actLen;
    logic [WIDTH-1:0] actSkip;
    logic [WIDTH-1:0] pendLen;
    logic [WIDTH-1:0] pendSkip;
    logic             pendValid;

    logic [WIDTH-1:0] reqLen;
    logic [WIDTH-1:0] reqSkip;
    logic             accept;
    logic             wrap;
    logic             transfer;

    // Clamp at acceptance so the pending registers always hold a legal frame.
    always_comb begin
        reqLen   = (cfg.cfgLen < TWO) ? TWO : cfg.cfgLen;
        reqSkip  = (cfg.cfgSkip > reqLen) ? reqLen : cfg.cfgSkip;
        accept   = cfg.cfgValid && !pendValid;
        wrap     = (p == (actLen - ONE));
        transfer = pendValid && (!enable || wrap);
    end

    assign cfg.cfgReady = !pendValid;

    always_ff @(posedge clk1G28) begin
        if (rst) begin
            p          <= ZERO;
            actLen     <= DEF_LEN;
            actSkip    <= DEF_SKIP;
            pendLen    <= DEF_LEN;
            pendSkip   <= DEF_SKIP;
            pendValid  <= 1'b0;
            skip       <= 1'b0;
            frameStart <= 1'b0;
            divClk     <= 1'b0;
        end else begin
            if (enable) begin
                p          <= wrap ? ZERO : (p + ONE);
                skip       <= (p < actSkip);
                frameStart <= (p == ZERO);
                divClk     <= (p < (actLen >> 1));
            end else begin
                p          <= ZERO;
                skip       <= 1'b0;
                frameStart <= 1'b0;
                divClk     <= 1'b0;
            end

            // accept and transfer are mutually exclusive: one needs pendValid low, the other high.
            if (transfer) begin
                actLen    <= pendLen;
                actSkip   <= pendSkip;
                pendValid <= 1'b0;
            end
            if (accept) begin
                pendLen   <= reqLen;
                pendSkip  <= reqSkip;
                pendValid <= 1'b1;
            end
        end
    end
endmodule

// File: doc/fb_skip_controller.md
FB_SKIP_CONTROLLER -- requirements
Module: fb_skip_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 6, counter and config width.
REQ-002 SHALL have parameter DEFAULT_LEN, default 32, frame length after reset.
REQ-003 SHALL have parameter DEFAULT_SKIP, default 0, skip count after reset.
REQ-004 SHALL have port clk1G28  input  1  single clock, the prescaler output; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  run when high; hold idle when low.
REQ-007 SHALL have port cfgValid  input  1  new configuration offered.
REQ-008 SHALL have port cfgLen  input  WIDTH  requested frame length M, in clk1G28 cycles.
REQ-009 SHALL have port cfgSkip  input  WIDTH  requested skips per frame S.
REQ-010 SHALL have port cfgReady  output  1  high when no configuration is pending.
REQ-011 SHALL have port skip  output  1  skip request to the prescaler; each high cycle stretches one prescaler period by one input cycle.
REQ-012 SHALL have port frameStart  output  1  one-cycle pulse marking frame phase 0.
REQ-013 SHALL have port divClk  output  1  divided feedback clock, one period per frame.

Function
REQ-014 SHALL keep a phase counter p (WIDTH bits) and active registers actLen and actSkip.
REQ-015 SHALL, while enable=1, advance p by 1 each cycle and wrap to 0 when p==actLen-1.
REQ-016 SHALL register all outputs, giving a latency of one cycle from p to the outputs: skip=(p<actSkip), frameStart=(p==0), divClk=(p<actLen>>1).
REQ-017 SHALL therefore span 2*M+S clk2G56 cycles per frame.
REQ-018 SHALL clamp actLen to a minimum of 2 when a cfgLen of 0 or 1 is accepted.
REQ-019 SHALL clamp actSkip to actLen when the accepted cfgSkip exceeds the clamped length.
REQ-020 SHALL accept a configuration when cfgValid&&cfgReady, storing it in pending registers and dropping cfgReady the next cycle.
REQ-021 SHALL, while enable=1, transfer pending to active only on the wrap cycle (p==actLen-1 -> 0), so a frame is never split between configurations, and then raise cfgReady the next cycle.
REQ-022 SHALL, while enable=0, transfer pending to active on the cycle after acceptance.
REQ-023 SHALL handle cfgValid coinciding with the wrap cycle while cfgReady=1 as accepted but applied at the next wrap, not the current one.
REQ-024 SHALL ignore cfgValid while cfgReady=0, leaving the first pending configuration intact.
REQ-025 SHALL, while enable=0, hold p at 0 and drive skip, frameStart and divClk to 0 one cycle later.
REQ-026 SHALL, when enable rises, run p from 0 so that the first frameStart appears one cycle after the rising edge.
REQ-027 SHALL, when enable falls mid-frame, abort the frame immediately with no partial-frame completion.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set p=0, actLen=DEFAULT_LEN, actSkip=DEFAULT_SKIP, clear the pending state, and drive cfgReady=1, skip=0, frameStart=0 and divClk=0.
REQ-029 SHALL let rst override enable and cfgValid, including discarding a pending configuration when reset arrives mid-frame.
REQ-030 SHALL, after rst falls with enable=1, emit the first frameStart pulse one cycle later.

Verification
REQ-031 SHALL cover defaults: reset, then enable=1 -> frameStart every 32 cycles; divClk high 16 cycles and low 16 cycles; skip never high.
REQ-032 SHALL cover a mid-frame config change: cfgLen=10, cfgSkip=3 offered at p=5 -> current 32-cycle frame completes; next frames are 10 cycles with skip high on the first 3 and divClk high on the first 5; cfgReady low from acceptance until the cycle after the wrap.
REQ-033 SHALL cover clamping: cfgLen=1, cfgSkip=7 -> actLen=2, actSkip=2; skip and divClk patterns consistent with M=2, S=2 (skip constant 1; divClk toggling 1,0; frameStart every 2 cycles).
REQ-034 SHALL cover enable toggling: deassert at p=12 -> outputs 0 one cycle later; reassert 5 cycles later -> frameStart one cycle after the rising edge and a full 32-cycle frame.
REQ-035 SHALL cover back-to-back config: second cfgValid while cfgReady=0 -> ignored; only the first configuration is applied.
REQ-036 SHALL cover reset mid-operation: rst at p=7 with a pending config -> pending discarded; actLen=32 restored; cfgReady=1 and all other outputs 0 after the reset edge.
